// File: rtl/hazard_ctrl_if.sv
// Hazard controller signal bundle: ID/EX/MEM hazard inputs plus pipeline
// control, status and counter outputs.
interface hazard_ctrl_if #(parameter int CNT_W = 32);
  logic [4:0]       rs_id, rt_id, rt_ex;
  logic             uses_rs_id, uses_rt_id, mem_read_ex;
  logic             branch_ex, take_branch_ex;
  logic             dmem_req_mem, dmem_ready, cnt_clear;
  logic             pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cycles, flush_events;
  logic [1:0]       state;

  modport master (
    output rs_id, rt_id, rt_ex, uses_rs_id, uses_rt_id, mem_read_ex,
           branch_ex, take_branch_ex, dmem_req_mem, dmem_ready, cnt_clear,
    input  pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold,
           mem_timeout, stall_cycles, flush_events, state
  );
  modport slave (
    input  rs_id, rt_id, rt_ex, uses_rs_id, uses_rt_id, mem_read_ex,
           branch_ex, take_branch_ex, dmem_req_mem, dmem_ready, cnt_clear,
    output pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold,
           mem_timeout, stall_cycles, flush_events, state
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch squash, memory-wait
// freeze, redirect window, sticky wait timeout and saturating perf counters.
module hazard_ctrl #(
  parameter int REDIRECT_CYCLES = 0,
  parameter int TIMEOUT         = 255,
  parameter int CNT_W           = 32
) (
  input logic          clk,
  input logic          reset,
  hazard_ctrl_if.slave hif
);
  localparam int             WW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0]  TO = WW'(TIMEOUT);
  localparam logic [2:0]     RC = 3'(REDIRECT_CYCLES);

  typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, REDIRECT = 2'd2} state_t;

  state_t            state, state_nxt;
  logic [WW-1:0]     wait_cnt, wait_nxt;
  logic [2:0]        redir_cnt, redir_nxt;
  logic              mem_stall, br_taken, lu_hazard;
  logic              timeout_r;
  logic [CNT_W-1:0]  stall_r, flush_r;

  assign mem_stall = hif.dmem_req_mem & ~hif.dmem_ready;
  assign br_taken  = hif.branch_ex & hif.take_branch_ex;
  assign lu_hazard = hif.mem_read_ex & (hif.rt_ex != 5'd0) &
                     ((hif.uses_rs_id & (hif.rs_id == hif.rt_ex)) |
                      (hif.uses_rt_id & (hif.rt_id == hif.rt_ex)));

  // Control outputs: mem_stall > br_taken > redirect window > load-use.
  always_comb begin
    hif.pc_write    = 1'b1;
    hif.if_id_write = 1'b1;
    hif.if_id_flush = 1'b0;
    hif.id_ex_flush = 1'b0;
    hif.pipe_hold   = 1'b0;
    if (mem_stall) begin
      hif.pipe_hold   = 1'b1;
      hif.pc_write    = 1'b0;
      hif.if_id_write = 1'b0;
    end else if (br_taken) begin
      hif.if_id_flush = 1'b1;
      hif.id_ex_flush = 1'b1;
    end else if (state == REDIRECT) begin
      hif.if_id_flush = 1'b1;
    end else if (lu_hazard) begin
      hif.pc_write    = 1'b0;
      hif.if_id_write = 1'b0;
      hif.id_ex_flush = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    redir_nxt = redir_cnt;
    case (state)
      RUN: begin
        if (mem_stall) begin
          state_nxt = MEM_WAIT;
          wait_nxt  = WW'(1);
        end else if (br_taken && RC != 3'd0) begin
          state_nxt = REDIRECT;
          redir_nxt = RC;
        end
      end
      MEM_WAIT: begin
        if (mem_stall) begin
          if (wait_cnt != '1) wait_nxt = wait_cnt + 1'b1;
        end else begin
          // The held branch resolves on the release cycle and opens its window.
          wait_nxt = '0;
          if (br_taken && RC != 3'd0) begin
            state_nxt = REDIRECT;
            redir_nxt = RC;
          end else begin
            state_nxt = RUN;
          end
        end
      end
      REDIRECT: begin
        if (!mem_stall) begin
          if (br_taken) begin
            redir_nxt = RC;
          end else if (redir_cnt <= 3'd1) begin
            state_nxt = RUN;
            redir_nxt = 3'd0;
          end else begin
            redir_nxt = redir_cnt - 3'd1;
          end
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= RUN;
      wait_cnt  <= '0;
      redir_cnt <= '0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_nxt;
      redir_cnt <= redir_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_r   <= '0;
      flush_r   <= '0;
      timeout_r <= 1'b0;
    end else if (hif.cnt_clear) begin
      stall_r   <= '0;
      flush_r   <= '0;
      timeout_r <= 1'b0;
    end else begin
      if (!hif.pc_write && stall_r != '1) stall_r <= stall_r + 1'b1;
      if (br_taken && !mem_stall && flush_r != '1) flush_r <= flush_r + 1'b1;
      if (state_nxt == MEM_WAIT && mem_stall && wait_nxt >= TO) timeout_r <= 1'b1;
    end
  end

  assign hif.mem_timeout  = timeout_r;
  assign hif.stall_cycles = stall_r;
  assign hif.flush_events = flush_r;
  assign hif.state        = state;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (REDIRECT_CYCLES=1, TIMEOUT=4, CNT_W=8).
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(8)) hif ();

  hazard_ctrl #(.REDIRECT_CYCLES(1), .TIMEOUT(4), .CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .hif   (hif.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    hif.rs_id = 5'd0; hif.rt_id = 5'd0; hif.rt_ex = 5'd0;
    hif.uses_rs_id = 1'b0; hif.uses_rt_id = 1'b0; hif.mem_read_ex = 1'b0;
    hif.branch_ex = 1'b0; hif.take_branch_ex = 1'b0;
    hif.dmem_req_mem = 1'b0; hif.dmem_ready = 1'b0; hif.cnt_clear = 1'b0;
  endtask

  task automatic lu_on();
    hif.mem_read_ex = 1'b1; hif.rt_ex = 5'd8; hif.rs_id = 5'd8; hif.uses_rs_id = 1'b1;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    #3;
    chk("rst_state", 32'(hif.state), 0);
    chk("rst_stall", 32'(hif.stall_cycles), 0);
    chk("rst_flush", 32'(hif.flush_events), 0);
    chk("rst_tmo", 32'(hif.mem_timeout), 0);
    chk("rst_pcw", 32'(hif.pc_write), 1);
    chk("rst_hold", 32'(hif.pipe_hold), 0);
    #4 reset = 1'b0;
    tick();
    chk("norm_pcw", 32'(hif.pc_write), 1);
    chk("norm_ifw", 32'(hif.if_id_write), 1);
    chk("norm_flush", {30'd0, hif.if_id_flush, hif.id_ex_flush}, 0);

    // Load-use: one bubble, then the load is in MEM
    lu_on(); #1;
    chk("lu_pcw", 32'(hif.pc_write), 0);
    chk("lu_ifw", 32'(hif.if_id_write), 0);
    chk("lu_idex", 32'(hif.id_ex_flush), 1);
    tick(); idle(); #1;
    chk("lu_cnt", 32'(hif.stall_cycles), 1);
    chk("lu_after_pcw", 32'(hif.pc_write), 1);

    // No-stall cases (combinational only)
    hif.mem_read_ex = 1'b1; hif.rt_ex = 5'd0; hif.rs_id = 5'd0; hif.uses_rs_id = 1'b1; #1;
    chk("zero_pcw", 32'(hif.pc_write), 1);
    chk("zero_idex", 32'(hif.id_ex_flush), 0);
    hif.uses_rs_id = 1'b0; hif.rt_ex = 5'd9; hif.rt_id = 5'd9; hif.uses_rt_id = 1'b0; #1;
    chk("rt_unused_pcw", 32'(hif.pc_write), 1);
    hif.uses_rt_id = 1'b1; #1;
    chk("rt_used_pcw", 32'(hif.pc_write), 0);
    idle(); #1;

    // Taken branch with a load-use in ID: squash wins
    lu_on(); hif.branch_ex = 1'b1; hif.take_branch_ex = 1'b1; #1;
    chk("br_ifid", 32'(hif.if_id_flush), 1);
    chk("br_idex", 32'(hif.id_ex_flush), 1);
    chk("br_pcw", 32'(hif.pc_write), 1);
    tick(); idle(); #1;
    chk("redir_state", 32'(hif.state), 2);
    chk("redir_ifid", 32'(hif.if_id_flush), 1);
    chk("redir_idex", 32'(hif.id_ex_flush), 0);
    chk("redir_pcw", 32'(hif.pc_write), 1);
    chk("br_cnt", 32'(hif.flush_events), 1);
    tick();
    chk("redir_done", 32'(hif.state), 0);
    chk("redir_done_ifid", 32'(hif.if_id_flush), 0);

    // Memory wait with a branch and load-use held underneath
    hif.dmem_req_mem = 1'b1; lu_on(); hif.branch_ex = 1'b1; hif.take_branch_ex = 1'b1; #1;
    chk("mw_hold", 32'(hif.pipe_hold), 1);
    chk("mw_pcw", 32'(hif.pc_write), 0);
    chk("mw_flush", {30'd0, hif.if_id_flush, hif.id_ex_flush}, 0);
    tick();
    chk("mw_state", 32'(hif.state), 1);
    tick(); tick();
    chk("mw_hold3", 32'(hif.pipe_hold), 1);
    chk("mw_tmo3", 32'(hif.mem_timeout), 0);
    chk("mw_stall", 32'(hif.stall_cycles), 4);
    idle(); hif.dmem_req_mem = 1'b1; hif.dmem_ready = 1'b1; #1;
    chk("mw_rel_hold", 32'(hif.pipe_hold), 0);
    chk("mw_rel_pcw", 32'(hif.pc_write), 1);
    tick(); idle(); #1;
    chk("mw_back", 32'(hif.state), 0);
    chk("mw_stall_end", 32'(hif.stall_cycles), 4);
    chk("mw_flush_cnt", 32'(hif.flush_events), 1);

    // Timeout: 6 wait cycles with TIMEOUT=4
    hif.dmem_req_mem = 1'b1;
    tick(); tick(); tick();
    chk("to_early", 32'(hif.mem_timeout), 0);
    tick(); tick(); tick();
    chk("to_set", 32'(hif.mem_timeout), 1);
    chk("to_state", 32'(hif.state), 1);
    hif.dmem_ready = 1'b1;
    tick(); idle(); #1;
    chk("to_sticky", 32'(hif.mem_timeout), 1);
    chk("to_state0", 32'(hif.state), 0);
    chk("to_stall", 32'(hif.stall_cycles), 10);

    // Clear beats a simultaneous stall increment
    hif.cnt_clear = 1'b1; lu_on();
    tick(); idle(); #1;
    chk("clr_stall", 32'(hif.stall_cycles), 0);
    chk("clr_flush", 32'(hif.flush_events), 0);
    chk("clr_tmo", 32'(hif.mem_timeout), 0);

    // Saturation of the 8-bit stall counter
    lu_on();
    for (int i = 0; i < 260; i++) tick();
    chk("sat_stall", 32'(hif.stall_cycles), 32'hFF);
    idle();

    // Asynchronous reset in MEM_WAIT
    hif.dmem_req_mem = 1'b1;
    tick(); tick();
    chk("ar_pre", 32'(hif.state), 1);
    #2 reset = 1'b1;
    #1;
    chk("ar_state", 32'(hif.state), 0);
    chk("ar_stall", 32'(hif.stall_cycles), 0);
    chk("ar_tmo", 32'(hif.mem_timeout), 0);
    #1 reset = 1'b0;
    idle();
    tick();

    // Memory stall inside the redirect window freezes it
    hif.branch_ex = 1'b1; hif.take_branch_ex = 1'b1;
    tick(); idle(); hif.dmem_req_mem = 1'b1; #1;
    chk("rm_hold", 32'(hif.pipe_hold), 1);
    chk("rm_ifid", 32'(hif.if_id_flush), 0);
    tick(); tick();
    chk("rm_state", 32'(hif.state), 2);
    hif.dmem_ready = 1'b1; #1;
    chk("rm_rel_ifid", 32'(hif.if_id_flush), 1);
    tick(); idle(); #1;
    chk("rm_done", 32'(hif.state), 0);
    chk("rm_flush_cnt", 32'(hif.flush_events), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
